// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped cache controller.
package cache_pkg;
    localparam int LINES_DEF  = 128;
    localparam int ADDR_W_DEF = 32;
    localparam int INDEX_W    = $clog2(LINES_DEF);
    localparam int TAG_W      = ADDR_W_DEF - INDEX_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        REFILL = 3'd2,
        WRMEM  = 3'd3,
        RESP   = 3'd4
    } state_e;
endpackage

// File: rtl/cache_line_ram.sv
// Data and tag storage for the cache: one write port, registered read, no reset.
module cache_line_ram
    import cache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int IDX_W = INDEX_W,
    parameter int TG_W  = TAG_W
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [TG_W-1:0]  wtag_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o,
    output logic [TG_W-1:0]  rtag_o
);
    logic [31:0]     data_mem [LINES];
    logic [TG_W-1:0] tag_mem  [LINES];
    logic [31:0]     rdata_q;
    logic [TG_W-1:0] rtag_q;

    // Array write and read-enable-gated registered read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            data_mem[waddr_i] <= wdata_i;
            tag_mem[waddr_i]  <= wtag_i;
        end
        if (re_i) begin
            rdata_q <= data_mem[raddr_i];
            rtag_q  <= tag_mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
    assign rtag_o  = rtag_q;
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through / write-allocate cache controller, one word per line.
// Defining CACHE_CTRL_STATS_EN adds the hit_cnt / miss_cnt read statistics outputs.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int LINES  = LINES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_flush,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
`ifdef CACHE_CTRL_STATS_EN
    output logic [31:0]       mem_wdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`else
    output logic [31:0]       mem_wdata
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TG_W  = ADDR_W - IDX_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic              vlat_q;
    logic [31:0]       rdata_q;
    logic [LINES-1:0]  valid_q;

    logic [IDX_W-1:0]  idx_s;
    logic [TG_W-1:0]   tag_s;
    logic [31:0]       ram_rdata_s;
    logic [TG_W-1:0]   ram_rtag_s;
    logic              ram_we_s;
    logic              ram_re_s;
    logic [31:0]       ram_wdata_s;
    logic              hit_s;

    assign idx_s = addr_q[IDX_W-1:0];
    assign tag_s = addr_q[ADDR_W-1:IDX_W];
    assign hit_s = vlat_q && (ram_rtag_s == tag_s);

    // The RAM read issued on the sampling edge is the latched line copy used in LOOKUP.
    cache_line_ram #(.LINES(LINES), .IDX_W(IDX_W), .TG_W(TG_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .waddr_i (idx_s),
        .wdata_i (ram_wdata_s),
        .wtag_i  (tag_s),
        .re_i    (ram_re_s),
        .raddr_i (cpu_addr[IDX_W-1:0]),
        .rdata_o (ram_rdata_s),
        .rtag_o  (ram_rtag_s)
    );

    // State register, request latch, valid vector and refill capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            vlat_q  <= 1'b0;
            rdata_q <= 32'd0;
            valid_q <= {LINES{1'b0}};
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cpu_flush) begin
                        valid_q <= {LINES{1'b0}};
                    end else if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        vlat_q  <= valid_q[cpu_addr[IDX_W-1:0]];
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        valid_q[idx_s] <= 1'b1;
                        rdata_q        <= mem_rdata;
                    end
                end
                WRMEM: begin
                    if (mem_ack) begin
                        valid_q[idx_s] <= 1'b1;
                        rdata_q        <= 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and output drive; array writes are suppressed while rst is high.
    always_comb begin
        state_d     = state_q;
        cpu_ready   = 1'b0;
        cpu_rdata   = 32'd0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {ADDR_W{1'b0}};
        mem_wdata   = 32'd0;
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_wdata_s = wdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_flush) begin
                    state_d = IDLE;
                end else if (cpu_req) begin
                    state_d  = LOOKUP;
                    ram_re_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    state_d = WRMEM;
                end else if (hit_s) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = ram_rdata_s;
                    state_d   = IDLE;
                end else begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    ram_we_s    = ~rst;
                    ram_wdata_s = mem_rdata;
                    state_d     = RESP;
                end else begin
                    state_d = REFILL;
                end
            end
            WRMEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    ram_we_s    = ~rst;
                    ram_wdata_s = wdata_q;
                    state_d     = RESP;
                end else begin
                    state_d = WRMEM;
                end
            end
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = rdata_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    // Read hit/miss counters, decided in LOOKUP; writes and flushes leave them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= 32'd0;
            miss_q <= 32'd0;
        end else if (state_q == LOOKUP && !we_q) begin
            if (hit_s) begin
                hit_q <= hit_q + 32'd1;
            end else begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed vector table, corner sequences and
// randomized traffic compared against a line-array reference model.
`timescale 1ns/1ps
module tb_cache_ctrl;
    localparam int LINES = 128;
    localparam int K_HIT = 0;
    localparam int K_MISS = 1;
    localparam int K_WR = 2;

    logic        clk = 1'b0;
    logic        rst, cpu_req, cpu_we, cpu_flush, cpu_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_flush(cpu_flush), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef CACHE_CTRL_STATS_EN
        .mem_wdata(mem_wdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`else
        .mem_wdata(mem_wdata)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Initial backing-memory content, shared by the memory environment and the model.
    function automatic logic [31:0] mem_init(input logic [31:0] a);
        if (a == 32'h5) return 32'hDEADBEEF;
        return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // ---------------- reference model ----------------
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] ref_mem [logic [31:0]];
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void model_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                     output int kind, output logic [31:0] rd);
        int idx;
        logic [31:0] tag;
        idx = int'(a[6:0]);
        tag = a >> 7;
        if (we) begin
            kind = K_WR;
            rd = 32'd0;
            ref_mem[a] = wd;
            m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = wd;
        end else if (m_valid[idx] && m_tag[idx] == tag) begin
            kind = K_HIT;
            rd = m_data[idx];
            m_hits++;
        end else begin
            kind = K_MISS;
            rd = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
            m_misses++;
            m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = rd;
        end
    endfunction

    // ---------------- backing memory environment ----------------
    logic [31:0] env_mem [logic [31:0]];
    int          ack_dly = 0;
    bit          auto_mem = 1'b1;
    bit          pulse_ack = 1'b0;
    bit          mon_en = 1'b0;
    int          wait_cnt = 0;
    int          n_rd = 0, n_wr = 0, stab_err = 0, idle_err = 0;
    logic [31:0] first_addr, first_wdata, last_addr, last_wdata;

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req !== 1'b1) begin
            wait_cnt = 0;
            if (mon_en && (mem_addr !== 32'd0 || mem_wdata !== 32'd0)) idle_err++;
        end
        if (pulse_ack) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hBAD0BAD0;
            pulse_ack = 1'b0;
        end else if (mem_req === 1'b1 && auto_mem) begin
            if (wait_cnt == 0) begin
                first_addr = mem_addr;
                first_wdata = mem_wdata;
            end else if (mem_addr !== first_addr || mem_wdata !== first_wdata) begin
                stab_err++;
            end
            if (wait_cnt >= ack_dly) begin
                mem_ack = 1'b1;
                last_addr = mem_addr;
                last_wdata = mem_wdata;
                if (mem_we) begin
                    n_wr++;
                    env_mem[mem_addr] = mem_wdata;
                end else begin
                    n_rd++;
                    mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : mem_init(mem_addr);
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Issue one request at a negedge; returns after the cycle following cpu_ready.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic fl,
                          output logic [31:0] rd, output int lat, output int nrdy);
        cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1; cpu_flush = fl;
        rd = 32'd0; lat = 0; nrdy = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            cpu_flush = 1'b0;
            if (cpu_ready === 1'b1) begin
                nrdy++; rd = cpu_rdata; lat = n + 1; break;
            end
        end
        cpu_req = 1'b0;
        @(negedge clk);
        if (cpu_ready === 1'b1) nrdy++;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic fl,
                           input int dly, output int kind_obs, output logic [31:0] rd, output int lat);
        int kind_exp, lat_exp, rd0, wr0, nrdy;
        logic [31:0] rd_exp;
        if (fl) model_clear();
        model_op(we, a, wd, kind_exp, rd_exp);
        lat_exp = (kind_exp == K_HIT) ? 2 : 4 + dly;
        if (fl) lat_exp++;
        ack_dly = dly;
        rd0 = n_rd; wr0 = n_wr;
        do_req(we, a, wd, fl, rd, lat, nrdy);
        kind_obs = (n_wr != wr0) ? K_WR : (n_rd != rd0) ? K_MISS : K_HIT;
        check("rdata", rd, rd_exp);
        check("latency", lat, lat_exp);
        check("kind", kind_obs, kind_exp);
        check("mem_ops", (n_rd - rd0) + (n_wr - wr0), (kind_exp == K_HIT) ? 0 : 1);
        check("ready_pulses", nrdy, 1);
        if (kind_exp != K_HIT) check("mem_addr", last_addr, a);
        if (kind_exp == K_WR) check("mem_wdata", last_wdata, wd);
`ifdef CACHE_CTRL_STATS_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
`endif
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        flush;
        int          kind;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int kind, lat, nrdy, saw;
        logic [31:0] rd, a;

        vecs[0] = '{1'b0, 32'h5,  32'h0,        1'b0, K_MISS, 32'hDEADBEEF, 4};
        vecs[1] = '{1'b0, 32'h5,  32'h0,        1'b0, K_HIT,  32'hDEADBEEF, 2};
        vecs[2] = '{1'b1, 32'h85, 32'h12345678, 1'b0, K_WR,   32'h0,        4};
        vecs[3] = '{1'b0, 32'h85, 32'h0,        1'b0, K_HIT,  32'h12345678, 2};
        vecs[4] = '{1'b0, 32'h85, 32'h0,        1'b1, K_MISS, 32'h12345678, 5};
        vecs[5] = '{1'b0, 32'h5,  32'h0,        1'b0, K_MISS, 32'hDEADBEEF, 4};
        vecs[6] = '{1'b1, 32'h5,  32'hCAFEF00D, 1'b0, K_WR,   32'h0,        4};
        vecs[7] = '{1'b0, 32'h5,  32'h0,        1'b0, K_HIT,  32'hCAFEF00D, 2};

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        cpu_flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef CACHE_CTRL_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Directed vectors: DUT against table constants (and the model inside run_txn).
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].flush, 0, kind, rd, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_kind", i), kind, vecs[i].kind);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Slow memory: read miss and write with ack delays 0, 1 and 7.
        for (int d = 0; d < 3; d++) begin
            int dly;
            dly = (d == 0) ? 0 : (d == 1) ? 1 : 7;
            run_txn(1'b0, 32'h1000 + 32'(d), 32'h0, 1'b1, dly, kind, rd, lat);
            run_txn(1'b1, 32'h2000 + 32'(d), 32'hA0000000 + 32'(d), 1'b0, dly, kind, rd, lat);
        end
        check("stable_mem_fields", stab_err, 0);

        // Randomized traffic over a few indices and tags to mix hits, misses and evictions.
        for (int t = 0; t < 120; t++) begin
            logic [31:0] idx, tag;
            logic        we, fl;
            int          dly;
            idx = ($urandom_range(0, 4) == 4) ? 32'd127 : 32'($urandom_range(0, 3));
            tag = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
            a = (tag << 7) | idx;
            we = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            dly = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 3));
            run_txn(we, a, $urandom, fl, dly, kind, rd, lat);
        end

        // Reset in the middle of a refill, with a stray ack arriving afterwards.
        cpu_flush = 1'b1;
        @(negedge clk);
        cpu_flush = 1'b0;
        model_clear();
        auto_mem = 1'b0;
        cpu_we = 1'b0; cpu_addr = 32'h305; cpu_wdata = 32'd0; cpu_req = 1'b1;
        saw = 0; nrdy = 0;
        for (int n = 0; n < 10 && saw == 0; n++) begin
            @(negedge clk);
            if (cpu_ready === 1'b1) nrdy++;
            if (mem_req === 1'b1) saw = 1;
        end
        check("rst_refill_reached", saw, 1);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        if (cpu_ready === 1'b1) nrdy++;
        rst = 1'b0;
        @(posedge clk);
        #1 pulse_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ready === 1'b1) nrdy++;
        end
        check("rst_mid_no_ready", nrdy, 0);
        auto_mem = 1'b1;
        model_clear();
        m_hits = 0; m_misses = 0;
`ifdef CACHE_CTRL_STATS_EN
        check("rst_mid_hit_cnt", hit_cnt, 32'd0);
        check("rst_mid_miss_cnt", miss_cnt, 32'd0);
`endif
        run_txn(1'b0, 32'h305, 32'h0, 1'b0, 2, kind, rd, lat);
        check("rst_mid_then_miss", kind, K_MISS);

        check("stable_mem_fields_final", stab_err, 0);
        check("idle_mem_outputs_zero", idle_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 128, number of direct-mapped one-word lines (power of two).
REQ-002 SHALL have parameter ADDR_W, default 32, word-address width; index = addr[log2(LINES)-1:0], tag = remaining upper bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports cpu_req (in, 1, request), cpu_we (in, 1, 1=write), cpu_addr (in, ADDR_W, address) and cpu_wdata (in, 32, write data).
REQ-006 SHALL have ports cpu_flush (in, 1, invalidate all lines), cpu_ready (out, 1, one-cycle completion pulse) and cpu_rdata (out, 32, read data, valid when cpu_ready=1).
REQ-007 SHALL have ports mem_req (out, 1, backing-memory request), mem_we (out, 1, write), mem_addr (out, ADDR_W, address) and mem_wdata (out, 32, write data).
REQ-008 SHALL have ports mem_ack (in, 1, one-cycle completion) and mem_rdata (in, 32, read data, valid with mem_ack).

Function
REQ-009 SHALL implement FSM states IDLE, LOOKUP, REFILL, WRMEM and RESP.
REQ-010 IDLE: on cpu_req=1, SHALL latch addr/we/wdata and the indexed tag, valid bit and data, then go to LOOKUP.
REQ-011 Requester SHALL hold cpu_req and its fields stable until cpu_ready; the controller uses only the latched copy.
REQ-012 LOOKUP read hit (valid and tag equal): SHALL assert cpu_ready with cpu_rdata = line data in that cycle, then return to IDLE; latency 2 cycles from req sample.
REQ-013 LOOKUP read miss: SHALL go to REFILL and assert mem_req=1, mem_we=0, mem_addr=latched addr, held until mem_ack.
REQ-014 REFILL on mem_ack: SHALL write mem_rdata to the data line, write {valid=1, tag} to the tag line, capture rdata, then go to RESP.
REQ-015 LOOKUP write (hit or miss): SHALL go to WRMEM (write-through, write-allocate) and hold mem_req=1, mem_we=1, mem_addr and mem_wdata until mem_ack.
REQ-016 WRMEM on mem_ack: SHALL write cpu_wdata to the data line and {1, tag} to the tag line, then go to RESP.
REQ-017 RESP: SHALL pulse cpu_ready for exactly one cycle (cpu_rdata = refilled word for reads, 0 for writes), then go to IDLE.
REQ-018 cpu_ready SHALL never be high two consecutive cycles; the next request is sampled no earlier than the cycle after cpu_ready.
REQ-019 cpu_flush SHALL be acted on only in IDLE, clearing all valid bits in one cycle; if cpu_flush and cpu_req coincide, flush wins and the request is sampled the following cycle.
REQ-020 cpu_flush outside IDLE SHALL be ignored; the requester holds it until serviced.
REQ-021 mem_ack while mem_req=0 SHALL be ignored.
REQ-022 Outside REFILL/WRMEM, mem_req SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-023 The valid bit SHALL be a separate flop vector; data and tag arrays have no reset.

Reset
REQ-024 rst SHALL force IDLE, clear all valid bits and drive cpu_ready=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0 on the next edge.
REQ-025 rst mid-REFILL/WRMEM SHALL abandon the transaction without an array write; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-026 With CACHE_CTRL_STATS_EN defined, SHALL add outputs hit_cnt and miss_cnt (32 bits each): a read hit increments hit_cnt, a read miss increments miss_cnt, and writes count neither.
REQ-027 Counters SHALL wrap at 2^32-1 to 0, clear on rst, and be unaffected by flush.
REQ-028 Without CACHE_CTRL_STATS_EN, the ports and counters SHALL not exist and behaviour SHALL be otherwise identical.

Structure
REQ-029 Package cache_pkg SHALL hold the FSM state typedef, LINES/ADDR_W defaults and the derived INDEX_W/TAG_W constants.
REQ-030 One sub-module cache_line_ram SHALL hold the data and tag arrays: single write port, registered read, no reset.

Verification
REQ-031 After reset, read addr 0x00000005 with mem_rdata=0xDEADBEEF: SHALL show one mem_req read to 0x5, then cpu_ready with rdata 0xDEADBEEF; miss_cnt=1.
REQ-032 Repeat read of 0x5: SHALL assert cpu_ready 2 cycles after req with no mem_req, rdata 0xDEADBEEF; hit_cnt=1.
REQ-033 Write 0x12345678 to 0x85 (same index, new tag), then read 0x85: SHALL produce a memory write, then a hit returning 0x12345678; reading 0x5 then misses.
REQ-034 cpu_flush together with cpu_req for 0x85 in IDLE: the request SHALL be serviced next cycle as a miss.
REQ-035 rst asserted while mem_req is high in REFILL with mem_ack 2 cycles later: mem_req SHALL drop next cycle, no cpu_ready, and a subsequent read of that addr SHALL miss.
REQ-036 mem_ack delayed 0, 1 and 7 cycles: mem_req SHALL be held with stable addr/data, and exactly one cpu_ready per request.
